fpu_add_seq: RTL and testbench

Parameterised, multi-cycle IEEE-754-style floating-point adder/subtractor; the successor of the fixed single-precision FPU add datapath. Exponent and fraction widths are parameters, subtraction is a runtime mode, rounding is round-to-nearest-even with guard/round/sticky bits, and special operands are handled. It sits beside the integer ALU in the execute stage. A start/busy/done handshake lets the controller stall until the result is valid.

---
 rtl/fpu_add_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_add_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: multi-cycle parameterised floating-point adder/subtractor.
// Round-to-nearest-even with guard/round/sticky; denormals flush to zero.
// Start/busy/done handshake, one result every 5 cycles back-to-back.
module fpu_add_seq #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic [EXP_W+FRAC_W:0] BusA,
  input  logic [EXP_W+FRAC_W:0] BusB,
  output logic [EXP_W+FRAC_W:0] BusW,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            flags
);

  localparam int unsigned W   = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW  = FRAC_W + 4;
  localparam int unsigned LZW = $clog2(MW + 1);
  localparam int unsigned EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [EW-1:0] EXP_MAX  = {{(EW-EXP_W){1'b0}}, EXP_ONES};
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} stateT;

  stateT                  state;
  logic                   sX, sY, signR, zeroR, specHitQ;
  logic [EXP_W-1:0]       eX, diff;
  logic [MW-1:0]          mX, mY, mant;
  logic [MW:0]            sum;
  logic signed [EW-1:0]   expR;
  logic [W-1:0]           specValQ;
  logic [3:0]             specFlQ;

  // Leading-zero count of a mantissa; all-zero input returns MW.
  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = LZW'(MW - 1 - i);
    end
  endfunction

  logic             signA, signB, zeroA, zeroB, nanA, nanB, infA, infB, aGe;
  logic [EXP_W-1:0] expA, expB;
  logic [FRAC_W-1:0] fracA, fracB;
  logic [MW-1:0]    manA, manB;
  logic             specHit;
  logic [W-1:0]     specVal;
  logic [3:0]       specFl;

  // Operand decode, magnitude compare and special-operand result.
  always_comb begin
    signA = BusA[W-1];
    signB = BusB[W-1] ^ sub;
    expA  = BusA[W-2:FRAC_W];
    expB  = BusB[W-2:FRAC_W];
    fracA = BusA[FRAC_W-1:0];
    fracB = BusB[FRAC_W-1:0];
    zeroA = (expA == '0);
    zeroB = (expB == '0);
    nanA  = (expA == EXP_ONES) && (fracA != '0);
    nanB  = (expB == EXP_ONES) && (fracB != '0);
    infA  = (expA == EXP_ONES) && (fracA == '0);
    infB  = (expB == EXP_ONES) && (fracB == '0);
    manA  = zeroA ? '0 : {1'b1, fracA, 3'b000};
    manB  = zeroB ? '0 : {1'b1, fracB, 3'b000};
    aGe   = {expA, manA} >= {expB, manB};
    specHit = 1'b1;
    specVal = '0;
    specFl  = '0;
    if (nanA || nanB) begin
      specVal = QNAN;
    end else if (infA && infB && (signA != signB)) begin
      specVal = QNAN;
      specFl  = 4'b1000;
    end else if (infA) begin
      specVal = {signA, expA, fracA};
    end else if (infB) begin
      specVal = {signB, expB, fracB};
    end else if (zeroA && zeroB) begin
      specVal = {signA & signB, {(W-1){1'b0}}};
    end else if (zeroA) begin
      specVal = {signB, expB, fracB};
    end else if (zeroB) begin
      specVal = {signA, expA, fracA};
    end else begin
      specHit = 1'b0;
    end
  end

  logic [MW-1:0] shifted, lostMask, aligned;

  // Right-shift the smaller mantissa, folding shifted-out bits into sticky.
  always_comb begin
    shifted  = mY >> diff;
    lostMask = ~({MW{1'b1}} << diff);
    if (32'(diff) >= 32'(FRAC_W + 3)) aligned = {{(MW-1){1'b0}}, |mY};
    else aligned = {shifted[MW-1:1], shifted[0] | (|(mY & lostMask))};
  end

  logic [LZW-1:0]       lz;
  logic [MW-1:0]        normMant;
  logic signed [EW-1:0] normExp;
  logic                 normZero;

  // Normalise the raw sum: carry shifts right, otherwise shift out leading zeros.
  always_comb begin
    lz       = lzc(sum[MW-1:0]);
    normZero = (sum == '0);
    if (sum[MW]) begin
      normMant = {sum[MW:2], sum[1] | sum[0]};
      normExp  = expR + EW'(1);
    end else begin
      normMant = sum[MW-1:0] << lz;
      normExp  = expR - EW'(lz);
    end
  end

  logic                 inc, inexact;
  logic [FRAC_W+1:0]    rounded;
  logic signed [EW-1:0] rndExp;
  logic [FRAC_W-1:0]    rndFrac;
  logic [W-1:0]         resW;
  logic [3:0]           resF;

  // Round to nearest even, then resolve overflow, underflow and specials.
  always_comb begin
    inc     = mant[2] & (mant[1] | mant[0] | mant[3]);
    inexact = mant[2] | mant[1] | mant[0];
    rounded = {1'b0, mant[MW-1:3]} + (FRAC_W+2)'(inc);
    rndExp  = expR;
    rndFrac = rounded[FRAC_W-1:0];
    if (rounded[FRAC_W+1]) begin
      rndExp  = expR + EW'(1);
      rndFrac = rounded[FRAC_W:1];
    end
    if (specHitQ) begin
      resW = specValQ;
      resF = specFlQ;
    end else if (zeroR) begin
      resW = '0;
      resF = '0;
    end else if (rndExp >= EXP_MAX) begin
      resW = {signR, EXP_ONES, {FRAC_W{1'b0}}};
      resF = 4'b0101;
    end else if (rndExp <= EXP_ZERO) begin
      resW = {signR, {(W-1){1'b0}}};
      resF = 4'b0011;
    end else begin
      resW = {signR, rndExp[EXP_W-1:0], rndFrac};
      resF = {3'b000, inexact};
    end
  end

  // Sequencer: IDLE -> ALIGN -> ADD -> NORM -> ROUND, outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sX       <= 1'b0;
      sY       <= 1'b0;
      signR    <= 1'b0;
      zeroR    <= 1'b0;
      specHitQ <= 1'b0;
      eX       <= '0;
      diff     <= '0;
      mX       <= '0;
      mY       <= '0;
      mant     <= '0;
      sum      <= '0;
      expR     <= '0;
      specValQ <= '0;
      specFlQ  <= '0;
      BusW     <= '0;
      flags    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            specHitQ <= specHit;
            specValQ <= specVal;
            specFlQ  <= specFl;
            if (aGe) begin
              sX <= signA; eX <= expA; mX <= manA;
              sY <= signB; mY <= manB; diff <= expA - expB;
            end else begin
              sX <= signB; eX <= expB; mX <= manB;
              sY <= signA; mY <= manA; diff <= expB - expA;
            end
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          mY    <= aligned;
          state <= ADD;
        end
        ADD: begin
          sum   <= (sX == sY) ? ({1'b0, mX} + {1'b0, mY}) : ({1'b0, mX} - {1'b0, mY});
          expR  <= EW'(eX);
          signR <= sX;
          state <= NORM;
        end
        NORM: begin
          mant  <= normMant;
          expR  <= normExp;
          zeroR <= normZero;
          state <= ROUND;
        end
        ROUND: begin
          BusW  <= resW;
          flags <= resF;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_seq.sv
// Scoreboard bench for fpu_add_seq: single precision instance plus a half-width instance.
module tb_fpu_add_seq;

  logic        clk = 1'b0;
  logic        reset, start, sub, startH, subH;
  logic [31:0] BusA, BusB, BusW;
  logic [15:0] BusAH, BusBH, BusWH;
  logic        busy, done, busyH, doneH;
  logic [3:0]  flags, flagsH;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] w;
    logic [3:0]  f;
    logic [31:0] doneCyc;
  } sbEntry;

  sbEntry      q[$];
  sbEntry      qH[$];
  sbEntry      eMain, eHalf;
  int unsigned cyc = 0;
  int          opId = 0;
  int          nChecks = 0;
  int          nFails = 0;

  fpu_add_seq dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .BusA(BusA), .BusB(BusB), .BusW(BusW),
    .busy(busy), .done(done), .flags(flags)
  );

  fpu_add_seq #(.EXP_W(5), .FRAC_W(10)) dutH (
    .clk(clk), .reset(reset), .start(startH), .sub(subH),
    .BusA(BusAH), .BusB(BusBH), .BusW(BusWH),
    .busy(busyH), .done(doneH), .flags(flagsH)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check done latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pop and compare each single-precision result as done pulses.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checkVal("spurious done", 64'(done), 64'(0));
      end else begin
        eMain = q.pop_front();
        checkVal($sformatf("op%0d BusW", eMain.id), 64'(BusW), 64'(eMain.w));
        checkVal($sformatf("op%0d flags", eMain.id), 64'(flags), 64'(eMain.f));
        checkVal($sformatf("op%0d done cycle", eMain.id), 64'(cyc), 64'(eMain.doneCyc));
        checkVal($sformatf("op%0d busy in done", eMain.id), 64'(busy), 64'(0));
      end
    end
  end

  // Pop and compare each half-width result as doneH pulses.
  always @(negedge clk) begin
    if (doneH) begin
      if (qH.size() == 0) begin
        checkVal("spurious doneH", 64'(doneH), 64'(0));
      end else begin
        eHalf = qH.pop_front();
        checkVal($sformatf("op%0d BusWH", eHalf.id), 64'(BusWH), 64'(eHalf.w));
        checkVal($sformatf("op%0d flagsH", eHalf.id), 64'(flagsH), 64'(eHalf.f));
        checkVal($sformatf("op%0d doneH cycle", eHalf.id), 64'(cyc), 64'(eHalf.doneCyc));
      end
    end
  end

  // Called at a negedge just before the start edge: result due 5 counts later.
  task automatic pushExp(input bit sel, input logic [31:0] ew, input logic [3:0] ef);
    sbEntry e;
    opId++;
    e.id = 16'(opId);
    e.w = ew;
    e.f = ef;
    e.doneCyc = cyc + 5;
    if (sel) qH.push_back(e);
    else q.push_back(e);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ew, input logic [3:0] ef);
    BusA = a; BusB = b; sub = s; start = 1'b1;
    pushExp(1'b0, ew, ef);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic launchH(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] ew, input logic [3:0] ef);
    BusAH = a; BusBH = b; subH = s; startH = 1'b1;
    pushExp(1'b1, 32'(ew), ef);
    @(posedge clk);
    #1 startH = 1'b0;
  endtask

  task automatic waitDone(input bit sel);
    bit seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seen = sel ? doneH : done;
      if (seen) break;
      if (sel) checkVal("busyH while running", 64'(busyH), 64'(1));
      else checkVal("busy while running", 64'(busy), 64'(1));
    end
    checkVal("done within bound", 64'(seen), 64'(1));
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] ew, input logic [3:0] ef);
    @(negedge clk);
    launch(a, b, s, ew, ef);
    waitDone(1'b0);
  endtask

  task automatic runOpH(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] ew, input logic [3:0] ef);
    @(negedge clk);
    launchH(a, b, s, ew, ef);
    waitDone(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; BusA = '0; BusB = '0;
    startH = 1'b0; subH = 1'b0; BusAH = '0; BusBH = '0;
    repeat (2) @(negedge clk);
    checkVal("reset BusW", 64'(BusW), 64'(0));
    checkVal("reset flags", 64'(flags), 64'(0));
    checkVal("reset busy", 64'(busy), 64'(0));
    checkVal("reset done", 64'(done), 64'(0));
    checkVal("reset BusWH", 64'(BusWH), 64'(0));
    reset = 1'b0;

    // Arithmetic path, rounding ties, sticky, overflow and underflow
    runOp(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    runOp(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    runOp(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    runOp(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    runOp(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    runOp(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    runOp(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    runOp(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000);
    runOp(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);
    runOp(32'h4B7FFFFF, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0000);
    runOp(32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 4'b0001);
    runOp(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);

    // Special operands
    runOp(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    runOp(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    runOp(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    runOp(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    runOp(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000);
    runOp(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

    // Back-to-back: second start raised in the done cycle
    @(negedge clk);
    launch(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    waitDone(1'b0);
    launch(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    waitDone(1'b0);

    // start held through the operation must not spawn a second one
    @(negedge clk);
    BusA = 32'h3F800000; BusB = 32'h3F800000; sub = 1'b0; start = 1'b1;
    pushExp(1'b0, 32'h40000000, 4'b0000);
    @(posedge clk);
    #1 BusA = 32'h40400000; BusB = 32'h40400000;
    repeat (3) begin
      @(posedge clk);
      #1 checkVal("busy with start held", 64'(busy), 64'(1));
    end
    start = 1'b0;
    waitDone(1'b0);
    repeat (6) @(negedge clk);
    checkVal("no extra result pending", 64'(q.size()), 64'(0));

    // Reset while in NORM aborts without a done pulse
    @(negedge clk);
    launch(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("abort busy", 64'(busy), 64'(0));
    checkVal("abort done", 64'(done), 64'(0));
    checkVal("abort BusW", 64'(BusW), 64'(0));
    checkVal("abort flags", 64'(flags), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    repeat (8) @(negedge clk);
    checkVal("BusW held after abort", 64'(BusW), 64'(0));
    runOp(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);

    // Half-width instance
    runOpH(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    runOpH(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
    runOpH(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);

    repeat (4) @(negedge clk);
    checkVal("scoreboard drained", 64'(q.size() + qH.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
